// File: rtl/rr_arbiter16_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
package rr_arbiter16_pkg;

  localparam int unsigned NReq = 16;
  localparam int unsigned IdW  = 4;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  function automatic logic [NReq-1:0] id_to_onehot(input logic [IdW-1:0] id);
    logic [NReq-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter16_pick16.sv
// Rotating-priority picker: first set request at or after ptr, wrapping modulo 16.
module rr_arbiter16_pick16
  import rr_arbiter16_pkg::*;
(
  input  logic [NReq-1:0] req_i,
  input  logic [IdW-1:0]  ptr_i,
  output logic [IdW-1:0]  winner_o,
  output logic            found_o
);

  logic [IdW-1:0] idx;
  logic           hit;

  // found_o is the plain OR16; the top also exports it as any_req.
  assign found_o = |req_i;

  always_comb begin
    winner_o = '0;
    hit      = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NReq; i++) begin
      idx = ptr_i + IdW'(i);
      if (!hit && req_i[idx]) begin
        winner_o = idx;
        hit      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with per-owner hold budget and forced release.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NReq-1:0] req,
  output logic [NReq-1:0] grant,
  output logic [IdW-1:0]  grant_id,
  output logic            grant_valid,
  output logic            any_req,
  output logic            preempt
);

  arb_state_e      state_q, state_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [NReq-1:0] grant_q, grant_d;
  logic [IdW-1:0]  grant_id_q, grant_id_d;
  logic            grant_valid_q, grant_valid_d;
  logic            preempt_q, preempt_d;

  logic [IdW-1:0]  winner;
  logic            found;
  logic            budget_spent;

  rr_arbiter16_pick16 u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .found_o  (found)
  );

  assign budget_spent = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(MAX_HOLD));

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    preempt_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d       = id_to_onehot(winner);
          grant_id_d    = winner;
          grant_valid_d = 1'b1;
          hold_cnt_d    = HOLD_W'(1);
          state_d       = StGrant;
        end else begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
        end
      end
      StGrant: begin
        if (!req[grant_id_q] || budget_spent) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          ptr_d         = grant_id_q + IdW'(1);
          preempt_d     = req[grant_id_q];
          state_d       = StIdle;
        end else if (!(&hold_cnt_q)) begin
          // Saturates only matters for unlimited hold; a bounded budget never reaches all-ones.
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      preempt_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      preempt_q     <= preempt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign preempt     = preempt_q;
  assign any_req     = found;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Scoreboard bench for rr_arbiter16: a behavioural model queues expected outputs per edge.
module tb_rr_arbiter16;

  localparam int MaxHold = 16;

  logic        clk;
  logic        reset_n;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        grant_valid;
  logic        any_req;
  logic        preempt;

  rr_arbiter16 #(
    .MAX_HOLD (MaxHold),
    .HOLD_W   (5)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .any_req     (any_req),
    .preempt     (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] g;
    logic [3:0]  id;
    logic        v;
    logic        p;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  logic       m_valid = 1'b0;
  logic [3:0] m_id    = '0;
  int         m_ptr   = 0;
  int         m_hold  = 0;
  logic       m_pre   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst_n, input logic [15:0] r);
    m_pre = 1'b0;
    if (!rst_n) begin
      m_valid = 1'b0; m_id = '0; m_ptr = 0; m_hold = 0;
    end else if (!m_valid) begin
      for (int k = 0; k < 16; k++) begin
        int c;
        c = (m_ptr + k) % 16;
        if (r[c] && !m_valid) begin
          m_valid = 1'b1; m_id = 4'(c); m_hold = 1;
        end
      end
    end else if (!r[m_id]) begin
      m_valid = 1'b0; m_ptr = (int'(m_id) + 1) % 16;
    end else if (MaxHold != 0 && m_hold == MaxHold) begin
      m_valid = 1'b0; m_ptr = (int'(m_id) + 1) % 16; m_pre = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  // Drive one cycle, then compare the post-edge outputs against the queued expectation.
  task automatic cycle(input logic rst_n, input logic [15:0] r);
    exp_t e;
    reset_n = rst_n;
    req     = r;
    #1;
    check("any_req", 32'(any_req), 32'(|r));
    model_edge(rst_n, r);
    e.v  = m_valid;
    e.id = m_id;
    e.g  = m_valid ? (16'h1 << m_id) : 16'h0;
    e.p  = m_pre;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("grant", 32'(grant), 32'(e.g));
    check("grant_valid", 32'(grant_valid), 32'(e.v));
    check("preempt", 32'(preempt), 32'(e.p));
    if (e.v) check("grant_id", 32'(grant_id), 32'(e.id));
    check("inv_onehot", 32'($countones(grant) <= 1), 32'd1);
    check("inv_valid_or", 32'(grant_valid), 32'(|grant));
    if (grant_valid) check("inv_id_bit", 32'(grant[grant_id]), 32'd1);
    check("inv_pre_valid", 32'(preempt && grant_valid), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    req     = '0;
    @(posedge clk);
    #1;

    // 1: reset holds with all requests, then grant 0 one edge after release.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'hFFFF);
      check("t1_rst_grant", 32'(grant), 32'h0);
    end
    cycle(1'b1, 16'hFFFF);
    check("t1_first_grant", 32'(grant), 32'h0001);
    check("t1_first_id", 32'(grant_id), 32'd0);

    // 2: short voluntary hold.
    cycle(1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'h0010);
      check("t2_grant", 32'(grant), 32'h0010);
      check("t2_pre", 32'(preempt), 32'd0);
    end
    cycle(1'b1, 16'h0);
    check("t2_release", 32'(grant), 32'h0);

    // 3: two contenders, budget expiry and pointer wrap 15 -> 0.
    cycle(1'b0, 16'h0);
    for (int k = 0; k < 35; k++) begin
      cycle(1'b1, 16'h8001);
      if (k == 0 || k == 15) check("t3_lo", 32'(grant), 32'h0001);
      if (k == 16 || k == 33) begin
        check("t3_gap", 32'(grant), 32'h0);
        check("t3_pre", 32'(preempt), 32'd1);
      end
      if (k == 17 || k == 32) check("t3_hi", 32'(grant), 32'h8000);
      if (k == 34) check("t3_wrap", 32'(grant), 32'h0001);
    end

    // 4: lone requester gets 16 cycles, preempt, gap, then wins again.
    cycle(1'b0, 16'h0);
    begin
      int held;
      held = 0;
      for (int k = 0; k < 18; k++) begin
        cycle(1'b1, 16'h0004);
        if (grant == 16'h0004 && k < 16) held++;
        if (k == 16) check("t4_pre", 32'(preempt), 32'd1);
        if (k == 17) check("t4_again", 32'(grant), 32'h0004);
      end
      check("t4_hold_len", 32'(held), 32'd16);
    end

    // 5: pointer advances past owner 5, then past 6 wraps to 0.
    cycle(1'b0, 16'h0);
    for (int k = 0; k < 18; k++) cycle(1'b1, 16'h0060);
    check("t5_next", 32'(grant), 32'h0040);
    cycle(1'b1, 16'h0021);
    check("t5_rel6", 32'(grant), 32'h0);
    cycle(1'b1, 16'h0021);
    check("t5_wrap", 32'(grant), 32'h0001);

    // 6: mid-grant reset clears pointer, then random run.
    cycle(1'b0, 16'h0);
    cycle(1'b1, 16'h0004);
    cycle(1'b1, 16'h0000);
    cycle(1'b1, 16'h0100);
    cycle(1'b1, 16'h0100);
    check("t6_owner", 32'(grant), 32'h0100);
    cycle(1'b0, 16'h0100);
    check("t6_rst_grant", 32'(grant), 32'h0);
    check("t6_rst_id", 32'(grant_id), 32'd0);
    cycle(1'b1, 16'h0012);
    check("t6_ptr0", 32'(grant), 32'h0002);
    for (int k = 0; k < 400; k++) begin
      logic [15:0] r;
      r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      cycle(($urandom_range(0, 60) != 0), r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
